// File: rtl/sign_lms_filter.sv
// Adaptive anti-noise FIR with sign-error LMS coefficient update.
// One multiplier is time-shared across the taps; one sample pair per ready_in/done_out handshake.
module sign_lms_filter #(
    parameter int NUM_TAPS = 32,
    parameter int MU_SHIFT = 8
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               ready_in,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] error_in,
    input  logic               adapt_en_in,
    output logic signed [15:0] y_out,
    output logic               done_out,
    output logic               busy_out
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int ACC_W = 32 + IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SHIFT,
        MAC,
        OUT
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [IDX_W-1:0]          idx_reg;
    logic signed [15:0]        x_lat_reg;
    logic                      err_neg_reg;
    logic signed [15:0]        xd_reg [NUM_TAPS];
    logic signed [15:0]        w_reg  [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [15:0]        y_reg;

    logic                      last_idx;
    logic signed [15:0]        xd_sel;
    logic signed [15:0]        w_sel;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [15:0]        upd_term;
    logic signed [16:0]        upd_sum;
    logic signed [15:0]        upd_sat;

    function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7fff;
        end
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] sat_acc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> 15;
        if ((&s[ACC_W-1:15]) || !(|s[ACC_W-1:15])) begin
            return s[15:0];
        end
        return s[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
    endfunction

    // Shared tap datapath: the same index selects the operand pair for both UPDATE and MAC.
    assign last_idx = (idx_reg == IDX_W'(NUM_TAPS - 1));
    assign xd_sel   = xd_reg[idx_reg];
    assign w_sel    = w_reg[idx_reg];
    assign prod     = 32'(xd_sel) * 32'(w_sel);
    assign acc_sum  = acc_reg + ACC_W'(prod);
    assign upd_term = xd_sel >>> MU_SHIFT;
    assign upd_sum  = err_neg_reg ? (17'(w_sel) + 17'(upd_term))
                                  : (17'(w_sel) - 17'(upd_term));
    assign upd_sat  = sat17(upd_sum);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ready_in) begin
                    state_next = (adapt_en_in && (error_in != 16'sd0)) ? UPDATE : SHIFT;
                end
            end
            UPDATE:  if (last_idx) state_next = SHIFT;
            SHIFT:   state_next = MAC;
            MAC:     if (last_idx) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            x_lat_reg   <= '0;
            err_neg_reg <= 1'b0;
            acc_reg     <= '0;
            y_reg       <= '0;
        end else begin
            state_reg <= state_next;
            // Counter runs only in the per-tap states; the power-of-two length makes it wrap to 0 on exit.
            if (state_reg == UPDATE || state_reg == MAC) begin
                idx_reg <= idx_reg + 1'b1;
            end else begin
                idx_reg <= '0;
            end
            if (state_reg == IDLE && ready_in) begin
                x_lat_reg   <= x_in;
                err_neg_reg <= error_in[15];
            end
            if (state_reg == SHIFT) begin
                acc_reg <= '0;
            end else if (state_reg == MAC) begin
                acc_reg <= acc_sum;
            end
            // Output is registered on the last MAC cycle so it is already valid during the done strobe.
            if (state_reg == MAC && last_idx) begin
                y_reg <= sat_acc(acc_sum);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            always_ff @(posedge clk_in or negedge reset_n_in) begin
                if (!reset_n_in) begin
                    w_reg[gi] <= '0;
                end else if (state_reg == UPDATE && idx_reg == IDX_W'(gi)) begin
                    w_reg[gi] <= upd_sat;
                end
            end

            if (gi == 0) begin : g_head
                always_ff @(posedge clk_in or negedge reset_n_in) begin
                    if (!reset_n_in) begin
                        xd_reg[gi] <= '0;
                    end else if (state_reg == SHIFT) begin
                        xd_reg[gi] <= x_lat_reg;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk_in or negedge reset_n_in) begin
                    if (!reset_n_in) begin
                        xd_reg[gi] <= '0;
                    end else if (state_reg == SHIFT) begin
                        xd_reg[gi] <= xd_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign y_out    = y_reg;
    assign done_out = (state_reg == OUT);
    assign busy_out = (state_reg != IDLE);

endmodule

// File: tb/tb_sign_lms_filter.sv
// Scoreboard bench for sign_lms_filter: directed handshake/sign cases, random samples and a closed loop
// against a simple cup model (feedback = primary-path ambient + speaker output).
module tb_sign_lms_filter;

    localparam int N  = 32;
    localparam int MU = 8;

    logic               clk_in      = 1'b0;
    logic               reset_n_in  = 1'b0;
    logic               ready_in    = 1'b0;
    logic signed [15:0] x_in        = '0;
    logic signed [15:0] error_in    = '0;
    logic               adapt_en_in = 1'b0;
    logic signed [15:0] y_out;
    logic               done_out;
    logic               busy_out;

    sign_lms_filter #(.NUM_TAPS(N), .MU_SHIFT(MU)) dut (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .ready_in    (ready_in),
        .x_in        (x_in),
        .error_in    (error_in),
        .adapt_en_in (adapt_en_in),
        .y_out       (y_out),
        .done_out    (done_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int y;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   xd_m[N];
    int   w_m[N];
    int   acc_cyc  = -100;
    int   done_cyc = -100;

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: applied only when the sample would be accepted (filter idle).
    function automatic void model_accept(input int x, input int e, input bit a);
        longint acc;
        int     lat;
        bit     upd;
        upd = a && (e != 0);
        if (upd) begin
            for (int k = 0; k < N; k++) begin
                int step;
                step = xd_m[k] >>> MU;
                w_m[k] = sat16((e > 0) ? longint'(w_m[k] - step) : longint'(w_m[k] + step));
            end
        end
        for (int k = N - 1; k > 0; k--) xd_m[k] = xd_m[k-1];
        xd_m[0] = x;
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(xd_m[k]) * longint'(w_m[k]);
        lat      = upd ? (2 * N + 2) : (N + 2);
        acc_cyc  = cyc;
        done_cyc = cyc + lat;
        sb_q.push_back('{y: sat16(acc >>> 15), done_cyc: done_cyc});
    endfunction

    // Called at a negedge; ready_in is held for exactly the current cycle.
    task automatic issue(input int x, input int e, input bit a);
        logic signed [15:0] x16;
        logic signed [15:0] e16;
        x16         = 16'(x);
        e16         = 16'(e);
        ready_in    = 1'b1;
        x_in        = x16;
        error_in    = e16;
        adapt_en_in = a;
        if (cyc > done_cyc) model_accept(int'(x16), int'(e16), a);
        @(negedge clk_in);
        ready_in    = 1'b0;
        x_in        = 16'($urandom);
        error_in    = 16'($urandom);
        adapt_en_in = 1'($urandom);
    endtask

    task automatic wait_done(output int y);
        while (cyc < done_cyc) @(negedge clk_in);
        y = int'(y_out);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        sb_q.delete();
        for (int k = 0; k < N; k++) begin
            xd_m[k] = 0;
            w_m[k]  = 0;
        end
        acc_cyc  = -100;
        done_cyc = -100;
        repeat (2) @(negedge clk_in);
        check("reset_y", y_out, 0);
        check("reset_done", done_out, 0);
        check("reset_busy", busy_out, 0);
        reset_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Monitor: compares DUT outputs against the scoreboard, independent of the stimulus thread.
    always @(negedge clk_in) begin
        if (reset_n_in) begin
            check("busy", busy_out, (cyc > acc_cyc && cyc <= done_cyc) ? 1 : 0);
            if (done_out) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t ex;
                    ex = sb_q.pop_front();
                    $display("sample done at cycle %0d: y_out=%0d expected %0d", cyc, y_out, ex.y);
                    check("y_out", y_out, ex.y);
                    check("done_cycle", cyc, ex.done_cyc);
                end
            end else if (sb_q.size() > 0 && cyc >= sb_q[0].done_cyc) begin
                exp_t ex;
                ex = sb_q.pop_front();
                check("missing_done", cyc, ex.done_cyc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no completion, expected $finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int    y;
        int    c0;
        int    fb_prev;
        real   sq_first;
        real   sq_last;
        int    rails;

        @(negedge clk_in);
        do_reset();

        // Latency/zero output without adaptation.
        issue(1000, 0, 0);
        wait_done(y);
        check("tp_noadapt_y", y, 0);

        // Positive error drives w[0] negative.
        do_reset();
        issue(16384, 0, 1);
        wait_done(y);
        check("tp_s1_y", y, 0);
        issue(16384, 1000, 1);
        wait_done(y);
        check("tp_adapt_pos_y", y, -32);

        // Zero error on sample 2 leaves coefficients alone.
        do_reset();
        issue(16384, 0, 1);
        wait_done(y);
        issue(16384, 0, 1);
        wait_done(y);
        check("tp_zero_err_y", y, 0);

        // Negative error drives w[0] positive.
        do_reset();
        issue(16384, 0, 1);
        wait_done(y);
        issue(16384, -1000, 1);
        wait_done(y);
        check("tp_adapt_neg_y", y, 32);

        // Strobes while busy and coincident with done must be ignored.
        c0 = cyc;
        issue(8000, 0, 0);
        while (cyc < c0 + 5) @(negedge clk_in);
        issue(-20000, 1234, 1);
        while (cyc < c0 + 20) @(negedge clk_in);
        issue(12345, -777, 1);
        while (cyc < c0 + N + 2) @(negedge clk_in);
        issue(-31000, 999, 1);
        issue(-3000, 0, 0);
        wait_done(y);
        check("strobe_follow_y", y, -6);

        // Abort mid-MAC; nothing may survive the reset.
        issue(5000, 0, 0);
        repeat (12) @(negedge clk_in);
        do_reset();
        issue(16384, 0, 1);
        wait_done(y);
        check("abort_y", y, 0);

        // Randomized samples with random gaps.
        for (int n = 0; n < 40; n++) begin
            int  xr;
            int  er;
            bit  ar;
            xr = int'($signed(16'($urandom)));
            er = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(16'($urandom)));
            ar = 1'($urandom);
            issue(xr, er, ar);
            wait_done(y);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end

        // Closed loop: primary path is -x/2, the speaker output adds directly.
        do_reset();
        fb_prev  = 0;
        sq_first = 0.0;
        sq_last  = 0.0;
        for (int n = 0; n < 500; n++) begin
            int xs;
            int d;
            int fb;
            xs = $rtoi(8000.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 48.0));
            issue(xs, fb_prev, 1'b1);
            wait_done(y);
            d  = -(xs / 2);
            fb = sat16(longint'(d + y));
            if (n < 100)  sq_first += real'(fb) * real'(fb);
            if (n >= 400) sq_last  += real'(fb) * real'(fb);
            fb_prev = fb;
        end
        $display("closed loop: sum sq first=%0.0f last=%0.0f", sq_first, sq_last);
        // RMS ratio below 25% is a squared-sum ratio below 1/16.
        check("closed_loop_converged", (sq_last * 16.0 < sq_first) ? 1 : 0, 1);
        rails = 0;
        for (int k = 0; k < N; k++) begin
            if (w_m[k] == 32767 || w_m[k] == -32768) rails++;
        end
        check("coef_rails", rails, 0);

        repeat (4) @(negedge clk_in);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
